dvs_event_uart_tx: RTL and testbench
====================================

// Module: dvs_event_uart_tx
// PURPOSE
//  Byte-stream-to-event framer. It drives the accelerator's event input (valid/ready, x/y/pol/ts).
//  Consumes raw bytes from the UART receiver and assembles fixed-length event packets.
//  Range-checks each packet, then presents it as a single held event to the gesture pipeline's InputFIFO.
//  It is the producer end of that event interface.
// PARAMETERS
//  SENSOR_RES      320     coords >= SENSOR_RES are rejected
//  TIMEOUT_CYCLES  12000   max idle cycles between bytes of one packet before resync (1 ms @ 12 MHz)
//  HDR_BYTE        8'hA5   packet sync byte
// PORTS
//  clk              in   1   system clock; all logic on posedge
//  rst              in   1   synchronous, active-high reset
//  rx_valid         in   1   one-cycle strobe: rx_data holds a received byte (no backpressure)
//  rx_data          in   8   received byte
//  event_valid      out  1   event held on event_* outputs
//  event_x          out  9   sensor x, 0..SENSOR_RES-1
//  event_y          out  9   sensor y, 0..SENSOR_RES-1
//  event_polarity   out  1   1 = ON event
//  event_ts         out  16  timestamp
//  event_ready      in   1   consumer accepts when event_valid && event_ready
//  stat_pkt_count   out  16  packets delivered to output stage, saturating
//  stat_drop_count  out  8   packets dropped (range/overflow/checksum), saturating
//  stat_resync      out  1   one-cycle pulse on inter-byte timeout abort
// BEHAVIOUR
//  Packet (6 bytes): HDR, x[7:0], y[7:0], {pol,5'b0,y[8],x[8]}, ts[15:8], ts[7:0].
//  FSM states: HUNT, COLLECT, COMMIT.
//   HUNT:    rx byte == HDR_BYTE -> COLLECT, byte index = 1; other bytes are ignored.
//   COLLECT: each rx byte is stored at its index; the last byte -> COMMIT. HDR_BYTE here is plain data (no escaping).
//            Idle counter clears on each byte; reaching TIMEOUT_CYCLES -> HUNT, partial packet discarded, stat_resync pulses.
//   COMMIT:  one cycle; validates, loads output stage or drops, then -> HUNT.
//            An rx byte arriving in COMMIT is evaluated as a HUNT byte.
//  Validation failure: x >= SENSOR_RES or y >= SENSOR_RES -> drop, stat_drop_count++.
//  Output stage: single-entry register.
//   event_valid rises the cycle after COMMIT, so latency from last byte strobe to event_valid is 2 cycles.
//   event_* stay stable while event_valid && !event_ready.
//   event_valid clears the cycle after the handshake, unless a new event is loaded in the same cycle.
//  Overflow: COMMIT while the stage is full and event_ready is low -> drop, stat_drop_count++.
//   If event_ready is high in that cycle, the stage drains and reloads the new event with no drop and no bubble.
//  Counters saturate at all-ones; stat_pkt_count increments only on successful load.
//  Reset (from any state, including mid-packet):
//   FSM -> HUNT, index/idle counter cleared, event_valid=0, event_x/y/ts=0, event_polarity=0, stats=0, stat_resync=0.
// CONFIGURATION
//  EVENT_CHECKSUM_EN defined: packet is 7 bytes; byte 6 = XOR of bytes 1..5.
//   On mismatch the packet is dropped in COMMIT, stat_drop_count++. Checksum is tested before range.
//  EVENT_CHECKSUM_EN undefined: 6-byte packet, no checksum logic.
// STRUCTURE
//  Package dvs_event_pkg: HDR_BYTE default, PKT_LEN (6/7 per macro), byte index localparams,
//   typedef struct packed {x[8:0], y[8:0], pol, ts[15:0]} dvs_event_t, FSM state enum.
//  Sub-module event_out_stage: single-entry valid/ready holding register with same-cycle drain+load,
//   reporting a "load_ok" / "overflow" result to the framer.
// TESTING
//  1. Bytes A5,10,20,01,12,34 with event_ready=1 -> one event x=0x110, y=0x020, pol=0, ts=0x1234, 2 cycles after last byte; pkt_count=1.
//  2. Same packet with event_ready=0 for 50 cycles -> event_valid and outputs stable 50 cycles, single handshake, no duplicate.
//  3. Packet x=320 (bytes A5,40,00,01,00,00) -> no event_valid, drop_count=1.
//  4. A5,10 then idle 12000 cycles, then a valid packet -> stat_resync pulses once; only the second packet is delivered.
//  5. Two back-to-back packets with event_ready=0 -> first held, second dropped (drop_count=1).
//     Repeat with ready raised on the second COMMIT cycle -> both delivered, no gap.
//  6. rst asserted mid-COLLECT and while event_valid=1 -> all outputs 0 next cycle; the following valid packet is decoded correctly.
//     With EVENT_CHECKSUM_EN, a corrupted checksum byte -> drop_count=1.

Source files
------------

// File: rtl/dvs_event_pkg.sv
// Shared types and constants for the UART byte-stream to DVS event framer.
// Pure definitions, no logic, so there is no latency.
// No backpressure here; EVENT_CHECKSUM_EN selects the 6- or 7-byte packet layout.
package dvs_event_pkg;

    // Default sync byte that opens every packet.
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    // Packet length in bytes, including the header byte.
`ifdef EVENT_CHECKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    // Byte positions within a packet.
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_HDR   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_X_LO  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_Y_LO  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_HI    = 3'd3;
    localparam logic [IDX_W-1:0] IDX_TS_HI = 3'd4;
    localparam logic [IDX_W-1:0] IDX_TS_LO = 3'd5;
    localparam logic [IDX_W-1:0] IDX_CKS   = 3'd6;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PKT_LEN - 1);

    // One decoded sensor event.
    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic        pol;
        logic [15:0] ts;
    } dvs_event_t;

    // Framer state encoding.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_HUNT    = 2'd0;
    localparam fsm_state_t ST_COLLECT = 2'd1;
    localparam fsm_state_t ST_COMMIT  = 2'd2;

endpackage

// File: rtl/dvs_event_uart_tx_out_stage.sv
// Single-entry valid/ready holding register for decoded events.
// Load to event_vld: 1 cycle. Drain and reload in the same cycle give no bubble.
// A load while full and not drained is refused and reported as overflow.
module event_out_stage
    import dvs_event_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_vld,
    input  dvs_event_t load_dat,
    output logic       load_ok,
    output logic       overflow,
    output logic       event_vld,
    output dvs_event_t event_dat,
    input  logic       event_rdy
);

    logic       held_vld;
    dvs_event_t held_dat;

    // The slot can take a new event when it is empty or is draining this cycle.
    assign load_ok   = load_vld && (!held_vld || event_rdy);
    assign overflow  = load_vld && held_vld && !event_rdy;
    assign event_vld = held_vld;
    assign event_dat = held_dat;

    // Hold the event until handshake; a simultaneous load replaces it seamlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_vld <= 1'b0;
            held_dat <= '0;
        end else if (load_ok) begin
            held_vld <= 1'b1;
            held_dat <= load_dat;
        end else if (held_vld && event_rdy) begin
            held_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/dvs_event_uart_tx.sv
// Frames UART bytes (HDR,xl,yl,{pol,y8,x8},tsh,tsl[,xor if EVENT_CHECKSUM_EN]) into range-checked events.
// Latency: last byte strobe to event_valid is 2 cycles (collect -> commit -> output stage).
// rx has no backpressure; a packet that finds the output stage full and not draining is dropped.
module dvs_event_uart_tx
    import dvs_event_pkg::*;
#(
    parameter int         SENSOR_RES     = 320,
    parameter int         TIMEOUT_CYCLES = 12000,
    parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        event_valid,
    output logic [8:0]  event_x,
    output logic [8:0]  event_y,
    output logic        event_polarity,
    output logic [15:0] event_ts,
    input  logic        event_ready,
    output logic [15:0] stat_pkt_count,
    output logic [7:0]  stat_drop_count,
    output logic        stat_resync
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    fsm_state_t         state;
    logic [IDX_W-1:0]   byte_idx;
    logic [IDLE_W-1:0]  idle_cnt;
    dvs_event_t         pkt_ev;
    dvs_event_t         out_ev;

    logic hdr_hit;
    logic byte_in;
    logic commit;
    logic in_range;
    logic cks_pass;
    logic pkt_good;
    logic load_vld;
    logic load_ok;
    logic overflow;
    logic drop;

    // Outside COLLECT (HUNT or the COMMIT cycle) only a sync byte matters.
    assign hdr_hit = (state != ST_COLLECT) && rx_valid && (rx_data == HDR_BYTE);
    assign byte_in = (state == ST_COLLECT) && rx_valid;
    assign commit  = (state == ST_COMMIT);

    // Framer state, byte index and inter-byte idle timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            byte_idx    <= '0;
            idle_cnt    <= '0;
            stat_resync <= 1'b0;
        end else begin
            stat_resync <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (byte_idx == IDX_LAST) begin
                            state    <= ST_COMMIT;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state       <= ST_HUNT;
                        byte_idx    <= '0;
                        idle_cnt    <= '0;
                        stat_resync <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    // HUNT and COMMIT both look for the next sync byte.
                    if (hdr_hit) begin
                        state    <= ST_COLLECT;
                        byte_idx <= IDX_X_LO;
                        idle_cnt <= '0;
                    end else begin
                        state    <= ST_HUNT;
                        byte_idx <= '0;
                    end
                end
            endcase
        end
    end

    // Scatter payload bytes straight into the event fields as they arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_ev <= '0;
        end else if (byte_in) begin
            case (byte_idx)
                IDX_X_LO:  pkt_ev.x[7:0]   <= rx_data;
                IDX_Y_LO:  pkt_ev.y[7:0]   <= rx_data;
                IDX_HI: begin
                    pkt_ev.pol  <= rx_data[7];
                    pkt_ev.y[8] <= rx_data[1];
                    pkt_ev.x[8] <= rx_data[0];
                end
                IDX_TS_HI: pkt_ev.ts[15:8] <= rx_data;
                IDX_TS_LO: pkt_ev.ts[7:0]  <= rx_data;
                default: ;
            endcase
        end
    end

`ifdef EVENT_CHECKSUM_EN
    logic [7:0] cks_acc;
    logic       cks_ok;

    // Running XOR of payload bytes; the final byte is compared against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cks_acc <= '0;
            cks_ok  <= 1'b0;
        end else if (hdr_hit) begin
            cks_acc <= '0;
            cks_ok  <= 1'b0;
        end else if (byte_in) begin
            if (byte_idx == IDX_CKS) begin
                cks_ok <= (cks_acc == rx_data);
            end else begin
                cks_acc <= cks_acc ^ rx_data;
            end
        end
    end

    assign cks_pass = cks_ok;
`else
    assign cks_pass = 1'b1;
`endif

    // Checksum and range are both required; which one failed does not matter for the count.
    assign in_range = (int'(pkt_ev.x) < SENSOR_RES) && (int'(pkt_ev.y) < SENSOR_RES);
    assign pkt_good = cks_pass && in_range;
    assign load_vld = commit && pkt_good;
    assign drop     = commit && (!pkt_good || overflow);

    event_out_stage u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (load_vld),
        .load_dat  (pkt_ev),
        .load_ok   (load_ok),
        .overflow  (overflow),
        .event_vld (event_valid),
        .event_dat (out_ev),
        .event_rdy (event_ready)
    );

    assign event_x        = out_ev.x;
    assign event_y        = out_ev.y;
    assign event_polarity = out_ev.pol;
    assign event_ts       = out_ev.ts;

    // Saturating delivery and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_count  <= '0;
            stat_drop_count <= '0;
        end else begin
            if (load_ok && (stat_pkt_count != '1)) begin
                stat_pkt_count <= stat_pkt_count + 1'b1;
            end
            if (drop && (stat_drop_count != '1)) begin
                stat_drop_count <= stat_drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dvs_event_uart_tx.sv
// Directed bench for dvs_event_uart_tx with a packet-level reference model.
// Model and literal checks are evaluated on the falling edge.
// Stimulus drives rx bytes and event_ready on the falling edge.
module tb_dvs_event_uart_tx;
    import dvs_event_pkg::*;

    localparam int T_OUT = 12000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        event_ready = 1'b0;
    logic        event_valid;
    logic [8:0]  event_x;
    logic [8:0]  event_y;
    logic        event_polarity;
    logic [15:0] event_ts;
    logic [15:0] stat_pkt_count;
    logic [7:0]  stat_drop_count;
    logic        stat_resync;

    always #5 clk = ~clk;

    dvs_event_uart_tx dut (
        .clk             (clk),
        .rst             (rst),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .event_valid     (event_valid),
        .event_x         (event_x),
        .event_y         (event_y),
        .event_polarity  (event_polarity),
        .event_ts        (event_ts),
        .event_ready     (event_ready),
        .stat_pkt_count  (stat_pkt_count),
        .stat_drop_count (stat_drop_count),
        .stat_resync     (stat_resync)
    );

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    endtask

    // ---------------- packet-level reference model ----------------
    bit          m_in_pkt, m_commit, m_vld, m_resync, m_good, m_hs;
    logic [7:0]  m_buf [0:7];
    int          m_n, m_idle, m_pkt, m_drop;
    logic [8:0]  m_x, m_y, m_px, m_py;
    logic        m_pol;
    logic [15:0] m_ts;
    int          hs_cnt = 0;
    int          resync_cnt = 0;

    always @(posedge clk) begin
        if (!rst && event_valid && event_ready) hs_cnt++;
        if (!rst && stat_resync) resync_cnt++;
        m_hs = m_vld && event_ready;
        if (rst) begin
            m_in_pkt = 0; m_commit = 0; m_vld = 0; m_resync = 0;
            m_n = 0; m_idle = 0; m_pkt = 0; m_drop = 0;
            m_x = 0; m_y = 0; m_pol = 0; m_ts = 0;
        end else begin
            m_resync = 0;
            if (m_commit) begin
                m_px   = {m_buf[3][0], m_buf[1]};
                m_py   = {m_buf[3][1], m_buf[2]};
                m_good = (m_px < 9'd320) && (m_py < 9'd320);
`ifdef EVENT_CHECKSUM_EN
                if ((m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4] ^ m_buf[5]) != m_buf[6]) m_good = 0;
`endif
                if (m_good && (!m_vld || event_ready)) begin
                    m_vld = 1; m_x = m_px; m_y = m_py; m_pol = m_buf[3][7];
                    m_ts = {m_buf[4], m_buf[5]};
                    if (m_pkt < 65535) m_pkt++;
                end else begin
                    if (m_drop < 255) m_drop++;
                    if (m_hs) m_vld = 0;
                end
                m_commit = 0;
            end else if (m_hs) begin
                m_vld = 0;
            end
            if (rx_valid) begin
                if (m_in_pkt) begin
                    m_buf[m_n] = rx_data; m_n++; m_idle = 0;
                    if (m_n == PKT_LEN) begin m_in_pkt = 0; m_commit = 1; end
                end else if (rx_data == 8'hA5) begin
                    m_in_pkt = 1; m_n = 1; m_idle = 0;
                end
            end else if (m_in_pkt) begin
                m_idle++;
                if (m_idle == T_OUT) begin m_in_pkt = 0; m_resync = 1; end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model",
                {3'b0, event_valid, stat_resync, stat_pkt_count, stat_drop_count,
                 m_vld ? {event_x, event_y, event_polarity, event_ts} : 35'b0},
                {3'b0, m_vld, m_resync, 16'(m_pkt), 8'(m_drop),
                 m_vld ? {m_x, m_y, m_pol, m_ts} : 35'b0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends HDR + five payload bytes (+ checksum, optionally corrupted).
    task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5, input bit corrupt);
        drive_byte(8'hA5);
        drive_byte(b1);
        drive_byte(b2);
        drive_byte(b3);
        drive_byte(b4);
        drive_byte(b5);
`ifdef EVENT_CHECKSUM_EN
        drive_byte(b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ (corrupt ? 8'h01 : 8'h00));
`else
        if (corrupt) drive_byte(8'h00);
`endif
    endtask

    int  hs0, r0, p0, d0;
    bit  stable;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {event_valid, event_x, event_y, event_polarity, event_ts,
                            stat_pkt_count, stat_drop_count, stat_resync}, 64'h0);
        chk_en = 1'b1;
        rst    = 1'b0;
        tick();

        // 1: basic decode and 2-cycle latency
        event_ready = 1'b1;
        send_pkt(8'h10, 8'h20, 8'h01, 8'h12, 8'h34, 1'b0);
        chk("t1_commit_cycle_valid", 64'(event_valid), 64'h0);
        tick();
        chk("t1_valid", 64'(event_valid), 64'h1);
        chk("t1_x", 64'(event_x), 64'h110);
        chk("t1_y", 64'(event_y), 64'h020);
        chk("t1_pol", 64'(event_polarity), 64'h0);
        chk("t1_ts", 64'(event_ts), 64'h1234);
        tick();
        chk("t1_valid_clears", 64'(event_valid), 64'h0);
        chk("t1_pkt_count", 64'(stat_pkt_count), 64'd1);

        // 2: held under backpressure for 50 cycles, single handshake
        event_ready = 1'b0;
        send_pkt(8'h10, 8'h20, 8'h01, 8'h12, 8'h34, 1'b0);
        tick();
        hs0 = hs_cnt;
        stable = 1'b1;
        repeat (50) begin
            if (!(event_valid === 1'b1 && event_x === 9'h110 && event_y === 9'h020 &&
                  event_polarity === 1'b0 && event_ts === 16'h1234)) stable = 1'b0;
            tick();
        end
        chk("t2_stable_50", 64'(stable), 64'h1);
        event_ready = 1'b1;
        tick();
        tick();
        chk("t2_one_handshake", 64'(hs_cnt - hs0), 64'd1);
        chk("t2_valid_clears", 64'(event_valid), 64'h0);
        chk("t2_pkt_count", 64'(stat_pkt_count), 64'd2);

        // 3: x = 320 rejected
        send_pkt(8'h40, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
        repeat (3) tick();
        chk("t3_drop_count", 64'(stat_drop_count), 64'd1);
        chk("t3_pkt_count", 64'(stat_pkt_count), 64'd2);

        // 4: inter-byte timeout then a good packet
        r0 = resync_cnt;
        drive_byte(8'hA5);
        drive_byte(8'h10);
        repeat (T_OUT + 5) tick();
        chk("t4_resync_once", 64'(resync_cnt - r0), 64'd1);
        send_pkt(8'h05, 8'h07, 8'h80, 8'hAB, 8'hCD, 1'b0);
        tick();
        chk("t4_event", {event_valid, event_x, event_y, event_polarity, event_ts},
            {1'b1, 9'h005, 9'h007, 1'b1, 16'hABCD});
        tick();
        chk("t4_pkt_count", 64'(stat_pkt_count), 64'd3);

        // 5a: back-to-back with consumer stalled -> second dropped
        event_ready = 1'b0;
        p0 = stat_pkt_count; d0 = stat_drop_count;
        send_pkt(8'h01, 8'h02, 8'h00, 8'h00, 8'h11, 1'b0);
        send_pkt(8'h03, 8'h04, 8'h03, 8'h22, 8'h33, 1'b0);
        tick();
        chk("t5a_drop", 64'(stat_drop_count - d0), 64'd1);
        chk("t5a_first_held", {event_valid, event_x}, {1'b1, 9'h001});
        event_ready = 1'b1;
        tick();
        tick();
        chk("t5a_pkt", 64'(stat_pkt_count - p0), 64'd1);

        // 5b: ready raised in the second commit cycle -> both delivered
        event_ready = 1'b0;
        p0 = stat_pkt_count; d0 = stat_drop_count;
        send_pkt(8'h01, 8'h02, 8'h00, 8'h00, 8'h11, 1'b0);
        send_pkt(8'h03, 8'h04, 8'h03, 8'h22, 8'h33, 1'b0);
        event_ready = 1'b1;
        tick();
        chk("t5b_second", {event_valid, event_x, event_y, event_ts},
            {1'b1, 9'h103, 9'h104, 16'h2233});
        chk("t5b_pkt", 64'(stat_pkt_count - p0), 64'd2);
        chk("t5b_no_drop", 64'(stat_drop_count - d0), 64'd0);
        tick();
        chk("t5b_drained", 64'(event_valid), 64'h0);

        // 6: reset mid-collect with an event held
        event_ready = 1'b0;
        send_pkt(8'h01, 8'h02, 8'h00, 8'h00, 8'h11, 1'b0);
        tick();
        drive_byte(8'hA5);
        drive_byte(8'h10);
        drive_byte(8'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_reset_zero", {event_valid, event_x, event_y, event_polarity, event_ts,
                              stat_pkt_count, stat_drop_count, stat_resync}, 64'h0);
        event_ready = 1'b1;
        send_pkt(8'h3F, 8'h3F, 8'h03, 8'hBE, 8'hEF, 1'b0);
        tick();
        chk("t6_boundary_319", {event_valid, event_x, event_y, event_ts},
            {1'b1, 9'h13F, 9'h13F, 16'hBEEF});
        tick();
        chk("t6_pkt_count", 64'(stat_pkt_count), 64'd1);

        // y = 320 rejected; header value used as payload data
        send_pkt(8'h00, 8'h40, 8'h02, 8'h00, 8'h00, 1'b0);
        repeat (2) tick();
        chk("y320_drop", 64'(stat_drop_count), 64'd1);
        send_pkt(8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0);
        tick();
        chk("hdr_as_data", {event_valid, event_x, event_y, event_ts},
            {1'b1, 9'h0A5, 9'h0A5, 16'hA5A5});
        tick();
`ifdef EVENT_CHECKSUM_EN
        send_pkt(8'h10, 8'h20, 8'h01, 8'h12, 8'h34, 1'b1);
        repeat (3) tick();
        chk("bad_checksum_drop", 64'(stat_drop_count), 64'd2);
`endif
        repeat (5) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
